// File: rtl/divisor_secuencial_pkg.sv
// Shared constants for the execute-stage divider: ALU opcodes and sequencer states.
package divisor_secuencial_pkg;

    localparam int ALUCONTROL_WIDTH = 5;

    localparam logic [ALUCONTROL_WIDTH-1:0] ALU_UDIV = 5'b01110;
    localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SDIV = 5'b01111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_paso.sv
// One combinational restoring-division step on unsigned magnitudes:
// shift {rem, quo} left by one and subtract the divisor when it fits.
module div_paso
    import divisor_secuencial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        // The remainder before the shift is always below the divisor, so the
        // difference fits back into WIDTH bits.
        if (shifted >= {1'b0, dsr_i}) begin
            rem_o = shifted[WIDTH-1:0] - dsr_i;
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divisor_secuencial.sv
// Iterative radix-2 UDIV/SDIV sequencer: stalls the pipeline for WIDTH+2 cycles
// after start, then presents quotient/remainder with a one-cycle done strobe.
module divisor_secuencial
    import divisor_secuencial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
    logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] rem_step, quo_step, dvd_abs, dsr_abs;
    logic             accept;

    div_paso #(.WIDTH(WIDTH)) u_paso (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dsr_i (dsr_q),
        .rem_o (rem_step),
        .quo_o (quo_step)
    );

    always_comb begin
        accept  = (state_q == ST_IDLE) && start && !abort;
        dvd_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        dsr_abs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    quo_d     = dvd_abs;
                    dsr_d     = dsr_abs;
                    rem_d     = '0;
                    cnt_d     = CNT_W'(WIDTH - 1);
                    neg_quo_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed && dividend[WIDTH-1];
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // A zero divisor leaves all-ones in quo; the architectural result is 0.
                if (dsr_q == '0) begin
                    quotient_d = '0;
                end else begin
                    quotient_d = neg_quo_q ? -quo_q : quo_q;
                end
                remainder_d = neg_rem_q ? -rem_q : rem_q;
                state_d     = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d     = ST_IDLE;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    // busy drops in DONE so the E stage advances and captures the result.
    assign busy      = accept || (state_q == ST_RUN) || (state_q == ST_FIX);
    assign done      = (state_q == ST_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// Randomized and directed checks of divisor_secuencial against an arithmetic reference model.
module tb_divisor_secuencial;

    localparam int W   = 32;
    localparam int LAT = 34;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         abort;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_eq, last_er;

    divisor_secuencial #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ARM semantics: truncating division, remainder takes the dividend's sign, x/0 = 0.
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        if (b == 0) begin
            q = '0;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end
    endfunction

    // Presents start for one cycle (cycle N) and returns #1 after the edge ending N.
    task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        chk("busy_start", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        start     = 1'b0;
        is_signed = 1'($urandom_range(1, 0));
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    // Follows cycles N+1 .. N+38 after a launch and scores the result.
    task automatic watch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq, er, gq, gr;
        int done_at  = -1;
        int done_cnt = 0;
        int busy_err = 0;
        gq = '0;
        gr = '0;
        model(s, a, b, eq, er);
        exp_q.push_back(eq);
        exp_q.push_back(er);
        for (int k = 1; k <= LAT + 4; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    gq = quotient;
                    gr = remainder;
                end
            end
            if ((k < LAT) != busy) busy_err++;
        end
        chk("hold_q", quotient, eq);
        chk("hold_r", remainder, er);
        chk("latency", W'(done_at), W'(LAT));
        chk("done_cnt", W'(done_cnt), 32'd1);
        chk("busy_win", W'(busy_err), 32'd0);
        chk("quotient", gq, exp_q.pop_front());
        chk("remainder", gr, exp_q.pop_front());
        last_eq = eq;
        last_er = er;
    endtask

    task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        launch(s, a, b);
        watch(s, a, b);
    endtask

    initial begin
        logic [W-1:0] eq_a, er_a, a, b;
        logic         s;
        int           done_cnt;

        reset     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        abort     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        reset = 1'b1;

        run_div(1'b0, 32'd100, 32'd7);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7);
        run_div(1'b1, 32'd100, 32'hFFFF_FFF9);
        run_div(1'b0, 32'h1234_5678, 32'd0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd0);

        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(1, 0));
            a = $urandom;
            case ($urandom_range(3, 0))
                0:       b = W'($urandom_range(15, 0));
                1:       b = $urandom >> $urandom_range(31, 1);
                2:       b = -W'($urandom_range(9, 1));
                default: b = $urandom;
            endcase
            run_div(s, a, b);
        end

        // Abort during RUN at N+10; outputs keep the previous result.
        launch(1'b0, 32'd5000, 32'd3);
        done_cnt = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        if (done) done_cnt++;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        if (done) done_cnt++;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", W'(done_cnt), 32'd0);
        chk("abort_q", quotient, last_eq);
        chk("abort_r", remainder, last_er);
        run_div(1'b1, 32'hFFFF_F000, 32'd9);

        // abort and start together: abort wins.
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_start_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        chk("abort_start_idle", W'(done_cnt), 32'd0);

        // Reset at N+20 of a divide.
        launch(1'b0, 32'd999, 32'd4);
        for (int k = 1; k <= 19; k++) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_q", quotient, 32'd0);
        chk("mid_rst_r", remainder, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_div(1'b0, 32'd12345, 32'd10);

        // Back-to-back: second start held from the DONE cycle.
        model(1'b0, 32'd77777, 32'd13, eq_a, er_a);
        launch(1'b0, 32'd77777, 32'd13);
        for (int k = 1; k <= LAT - 1; k++) @(negedge clk);
        @(posedge clk);
        #1;
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'hFFFF_0000;
        divisor   = 32'd6;
        @(negedge clk);
        chk("b2b_done", {31'd0, done}, 32'd1);
        chk("b2b_busy_done", {31'd0, busy}, 32'd0);
        chk("b2b_q", quotient, eq_a);
        chk("b2b_r", remainder, er_a);
        @(negedge clk);
        chk("b2b_busy_accept", {31'd0, busy}, 32'd1);
        chk("b2b_done_off", {31'd0, done}, 32'd0);
        chk("b2b_q_stable", quotient, eq_a);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        watch(1'b1, 32'hFFFF_0000, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divisor_secuencial.md
Name: divisor_secuencial

Overview:
- Iterative radix-2 divider sequencer for the UDIV (ALUControl 5'b01110) and SDIV (5'b01111) operations in the pipelined core's execute stage.
- Captures operands when the controller issues a divide, and holds the pipeline stall request until the result is ready.
- Presents quotient and remainder for exactly one cycle, in which the E stage advances.
- Sits beside the ALU; its start signal is the condition-gated divide decode from the controller.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, $clog2(WIDTH), width of the iteration counter; this is a derived localparam, not overridable.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  divide request: ALUControlE is UDIV or SDIV and CondExE is 1.
- is_signed  input  1  1 = SDIV, 0 = UDIV; sampled with start.
- dividend  input  WIDTH  Rn operand; sampled with start.
- divisor  input  WIDTH  Rm operand; sampled with start.
- abort  input  1  FlushE; cancels any operation in progress.
- busy  output  1  stall request to the hazard unit.
- done  output  1  one-cycle result-valid strobe.
- quotient  output  WIDTH  result quotient, valid when done=1.
- remainder  output  WIDTH  result remainder, valid when done=1; sign follows the dividend.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, all internal registers cleared. Outputs busy=0, done=0, quotient=0, remainder=0.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - When start=1 and abort=0, latch |dividend| and |divisor| (absolute value only if is_signed=1), neg_q = sign(dividend) XOR sign(divisor), and neg_r = sign(dividend).
  - Clear the partial remainder, set counter=WIDTH-1, go to RUN.
- RUN: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - If rem >= divisor magnitude, subtract it and set quo[0]=1.
  - Decrement the counter. When the counter was 0, go to FIX, so RUN lasts exactly WIDTH cycles.
- FIX: conditionally two's-complement-negate quo (if neg_q) and rem (if neg_r) into the output registers, then go to DONE.
- DONE: done=1 for this cycle only; next state is IDLE.
- Output timing:
  - quotient and remainder hold their value from FIX until the next FIX or reset.
  - They are don't-care outside done, but the bench checks that they are stable.
- busy:
  - Combinational: busy = (state==IDLE & start & ~abort) | state==RUN | state==FIX.
  - It is high in the same cycle start is presented, so the issuing instruction stalls immediately.
  - It is low in DONE, so the E stage advances and captures the result.
- Latency: start in cycle N gives done in cycle N+WIDTH+2; with WIDTH=32, done is in N+34.
- Divide by zero: the divisor magnitude is 0, so the quotient is forced to 0 in FIX and the remainder equals the dividend. This gives the ARM result of 0 with no trap. The cycle count is unchanged.
- SDIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This falls out of the unsigned-magnitude datapath; no special case is needed.
- abort:
  - In any state, the next state is IDLE, done is never asserted, and the output registers are unchanged.
  - abort has priority over start in the same cycle.
- start while not in IDLE: ignored. The controller never asserts it because the pipeline is stalled.
- start in the DONE cycle: ignored. A back-to-back divide is accepted in the following IDLE cycle.
- Reset mid-RUN: immediate return to IDLE; no done is produced.

Decomposition:
- Shared package holds:
  - ALUCONTROL_WIDTH (5).
  - ALU_UDIV = 5'b01110 and ALU_SDIV = 5'b01111.
  - The state encoding: IDLE 2'd0, RUN 2'd1, FIX 2'd2, DONE 2'd3.
- One sub-module is natural: div_paso, the combinational single restoring step. It takes rem, quo and divisor and returns the next rem and quo, so it can be unit-tested in isolation.
- The FSM, counter and sign logic stay in divisor_secuencial.

Test Plan:
- UDIV 100/7: start with is_signed=0 at cycle N. Required: busy=1 in cycles N..N+33, done=1 only at N+34, quotient=14, remainder=2.
- SDIV -100/7 (0xFFFFFF9C / 7). Required: quotient=0xFFFFFFF2 (-14), remainder=0xFFFFFFFE (-2). Then 100/-7. Required: quotient=-14, remainder=2.
- Divide by zero, UDIV 0x12345678/0. Required: done at N+34, quotient=0, remainder=0x12345678.
- SDIV 0x80000000/0xFFFFFFFF. Required: quotient=0x80000000, remainder=0. Also UDIV 0xFFFFFFFF/1. Required: quotient=0xFFFFFFFF, remainder=0.
- Abort and reset:
  - Pulse abort at N+10. Required: busy=0 from N+11, no done, and a new start at N+12 completes normally at N+46.
  - Assert reset low at N+20 of a separate divide. Required: immediate busy=0, done=0, quotient=0.
- Back-to-back: two divides with the second start held from N+34 (the DONE cycle). Required: the second start is ignored in DONE and accepted at N+35, done at N+69, with the first result stable during N+34.
